// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, reset PC and fetch state encoding
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int FIFO_DEPTH = 2;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_BUSY = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer of {addr, data} with flush over push
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, single-outstanding memory fetch and decoder handshake
module fetch_unit #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int FIFO_DEPTH = cpu_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] INS,
    output logic [ADDR_W-1:0] INS_addr,
    output logic              INS_valid,
    input  logic              INS_ready,
    input  logic              load_pc,
    input  logic [ADDR_W-1:0] new_pc
);

    import cpu_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [CW-1:0]     fifo_count;
    logic              push;
    logic              pop;
    logic              resp;
    logic              still_outstanding;
    logic              issue;
    logic [CW:0]       occ;

    // Responses are kept only in BUSY and never in a redirect cycle.
    always_comb begin
        resp = mem_rvalid && (state != FETCH_IDLE);
        push = mem_rvalid && (state == FETCH_BUSY) && !load_pc;
        pop  = INS_valid && INS_ready;
        still_outstanding = (state != FETCH_IDLE) && !mem_rvalid;
        occ = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
        issue = !load_pc && !still_outstanding && (occ < DEPTH_L);
    end

    // Next state and PC: redirect wins, then issue, then request completion.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (load_pc) begin
            state_nxt = still_outstanding ? FETCH_DROP : FETCH_IDLE;
            pc_nxt    = new_pc;
        end else if (issue) begin
            state_nxt = FETCH_BUSY;
            pc_nxt    = pc + ADDR_W'(1);
        end else if (resp) begin
            state_nxt = FETCH_IDLE;
        end
    end

    // State, PC and the registered memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH_IDLE;
            pc       <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            mem_req <= issue;
            if (issue) begin
                mem_addr <= pc;
            end
        end
    end

    // mem_addr holds the outstanding request address until the next issue.
    fetch_fifo #(
        .DEPTH(FIFO_DEPTH),
        .AW   (ADDR_W),
        .DW   (DATA_W),
        .CW   (CW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_addr(mem_addr),
        .push_data(mem_rdata),
        .pop      (pop),
        .flush    (load_pc),
        .count    (fifo_count),
        .head_addr(INS_addr),
        .head_data(INS)
    );

    assign INS_valid = (fifo_count != '0);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;

    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] INS;
    logic [15:0] INS_addr;
    logic        INS_valid;
    logic        INS_ready = 1'b0;
    logic        load_pc = 1'b0;
    logic [15:0] new_pc = 16'h0000;

    int n_total = 0;
    int n_pass = 0;
    int lat = 1;
    bit pend_v = 1'b0;
    int pend_cnt = 0;
    logic [15:0] pend_addr = 16'h0000;
    logic [15:0] exp_req = 16'h0000;
    logic [15:0] exp_q[$];

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .INS       (INS),
        .INS_addr  (INS_addr),
        .INS_valid (INS_valid),
        .INS_ready (INS_ready),
        .load_pc   (load_pc),
        .new_pc    (new_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory request side: one outstanding, addresses follow the bench PC model.
    initial forever begin
        @(negedge clk);
        if (mem_req) begin
            check("one_outstanding", 32'(pend_v), 32'd0);
            check("mem_addr_seq", 32'(mem_addr), 32'(exp_req));
            exp_req = exp_req + 16'd1;
            pend_v = 1'b1;
            pend_cnt = lat;
            pend_addr = mem_addr;
        end
    end

    // Memory response side: data = addr ^ A5A5 after lat cycles.
    initial forever begin
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        if (pend_v) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata = pend_addr ^ 16'hA5A5;
                pend_v = 1'b0;
            end
        end
    end

    // Decoder side: every completed handshake pops the scoreboard.
    initial forever begin
        logic [15:0] e;
        @(negedge clk);
        if (INS_valid && INS_ready) begin
            check("ins_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ins_addr", 32'(INS_addr), 32'(e));
                check("ins_data", 32'(INS), 32'(e ^ 16'hA5A5));
            end
        end
    end

    task automatic redirect(input logic [15:0] a);
        new_pc = a;
        load_pc = 1'b1;
        tick();
        load_pc = 1'b0;
        exp_req = a;
        exp_q.delete();
    endtask

    task automatic push_seq(input logic [15:0] a, input int n);
        logic [15:0] v;
        v = a;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            v = v + 16'd1;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!INS_valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(INS_valid), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!mem_req && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_ins_valid"}, 32'(INS_valid), 32'd0);
        check({tag, "_ins"}, 32'(INS), 32'd0);
        check({tag, "_ins_addr"}, 32'(INS_addr), 32'd0);
    endtask

    initial begin
        bit req_seen;
        bit hold_bad;
        int n;

        repeat (3) tick();
        check_zero("reset");

        // 1: sequential fetch from RESET_PC with 1-cycle memory
        push_seq(16'h0000, 4);
        INS_ready = 1'b1;
        rst = 1'b0;
        tick();
        check("t1_first_req", 32'(mem_req), 32'd1);
        check("t1_first_addr", 32'(mem_addr), 32'h0000);
        tick();
        check("t1_not_valid_yet", 32'(INS_valid), 32'd0);
        tick();
        check("t1_valid_2cyc", 32'(INS_valid), 32'd1);
        check("t1_next_addr", 32'(mem_addr), 32'h0001);
        drain("t1_drain");
        INS_ready = 1'b0;

        // 2: decoder stall fills the buffer and silences fetch
        redirect(16'h0100);
        push_seq(16'h0100, 4);
        wait_valid("t2_valid");
        req_seen = 1'b0;
        hold_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            req_seen = req_seen | mem_req;
            hold_bad = hold_bad | (INS_addr !== 16'h0100) | (INS !== (16'h0100 ^ 16'hA5A5));
        end
        check("t2_req_silent", 32'(req_seen), 32'd0);
        check("t2_head_held", 32'(hold_bad), 32'd0);
        check("t2_count_full", 32'(dut.fifo_count), 32'd2);
        INS_ready = 1'b1;
        tick();
        check("t2_resume_req", 32'(mem_req), 32'd1);
        check("t2_resume_addr", 32'(mem_addr), 32'h0102);
        drain("t2_drain");
        INS_ready = 1'b0;

        // 3: redirect while a 3-cycle request is in flight
        lat = 3;
        redirect(16'h0005);
        INS_ready = 1'b1;
        wait_req("t3_req5");
        check("t3_addr5", 32'(mem_addr), 32'h0005);
        tick();
        redirect(16'h0040);
        push_seq(16'h0040, 2);
        check("t3_state_drop", 32'(dut.state), 32'(FETCH_DROP));
        wait_req("t3_req40");
        check("t3_addr40", 32'(mem_addr), 32'h0040);
        drain("t3_drain");
        INS_ready = 1'b0;

        // 4: redirect coinciding with a response and a handshake
        redirect(16'h0080);
        push_seq(16'h0080, 1);
        wait_valid("t4_valid");
        repeat (3) tick();
        INS_ready = 1'b1;
        redirect(16'h0200);
        push_seq(16'h0200, 1);
        check("t4_flushed_valid", 32'(INS_valid), 32'd0);
        check("t4_flushed_count", 32'(dut.fifo_count), 32'd0);
        check("t4_state_idle", 32'(dut.state), 32'(FETCH_IDLE));
        drain("t4_drain");
        INS_ready = 1'b0;

        // 5: PC wraps past FFFF
        lat = 1;
        redirect(16'hFFFF);
        push_seq(16'hFFFF, 3);
        INS_ready = 1'b1;
        drain("t5_drain");
        INS_ready = 1'b0;

        // 6: reset mid-flight, stale response lands in IDLE
        lat = 3;
        redirect(16'h0300);
        push_seq(16'h0300, 1);
        n = 0;
        while (dut.fifo_count != 2 && n < 40) begin
            tick();
            n++;
        end
        check("t6_full", 32'(dut.fifo_count), 32'd2);
        INS_ready = 1'b1;
        tick();
        INS_ready = 1'b0;
        check("t6_req302", 32'(mem_req), 32'd1);
        check("t6_addr302", 32'(mem_addr), 32'h0302);
        repeat (2) tick();
        check("t6_state_busy", 32'(dut.state), 32'(FETCH_BUSY));
        check("t6_count_one", 32'(dut.fifo_count), 32'd1);
        rst = 1'b1;
        tick();
        check_zero("t6_reset");
        rst = 1'b0;
        exp_req = 16'h0000;
        exp_q.delete();
        push_seq(16'h0000, 2);
        INS_ready = 1'b1;
        tick();
        check("t6_post_req", 32'(mem_req), 32'd1);
        check("t6_post_addr", 32'(mem_addr), 32'h0000);
        check("t6_stale_dropped", 32'(INS_valid), 32'd0);
        drain("t6_drain");
        INS_ready = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
